serial_sub: RTL
===============

# serial_sub

Bit-serial N-bit subtractor built around a single full-subtractor cell (a, b, bin -> diff, borrow) with a registered borrow. It sits directly upstream of that cell: it shifts operands LSB-first into the cell, feeds the registered borrow back as the next bin, and collects diff bits into a result register. Intended for area-constrained datapaths where one subtract every WIDTH+1 cycles is sufficient.

## Interface
- WIDTH, 8, operand and result width in bits (>= 2)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- bin  input  1  initial borrow-in; captured on accepted start
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- borrow  output  1  final borrow-out (1 when a < b + bin, unsigned)
- zero, ovf  output  1 each  status flags; present only with SERIAL_SUB_FLAGS_EN

## Operation
- States: IDLE, SHIFT, DONE. Reset state IDLE.
- IDLE: if start=1, load a_sh<=a, b_sh<=b, br<=bin, cnt<=0; go to SHIFT. Otherwise hold.
- SHIFT: each cycle compute cell on (a_sh[0], b_sh[0], br):
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - a_sh, b_sh shift right by 1; d enters res_sh at MSB, res_sh shifts right; br <= br_next; cnt <= cnt+1.
  - After the WIDTH-th shift (cnt == WIDTH-1 at the edge), go to DONE; diff <= final result, borrow <= final br_next, in that same edge.
- DONE: done=1 for exactly this cycle; next edge returns to IDLE.
- diff/borrow (and flags) hold their value from the last DONE until the next DONE or reset; they do not change during SHIFT.
- start asserted in SHIFT or DONE is ignored (no queueing); a/b/bin changes during SHIFT have no effect.
- cnt width: clog2(WIDTH)+1 bits; no wrap within an operation.

## Timing
- Reset (rst=1 at an edge): state IDLE; busy=0, done=0, diff=0, borrow=0, zero=0, ovf=0; shift registers, br, cnt cleared. Applies mid-operation: operation aborted, no done pulse.
- rst and start at the same edge: rst wins.
- start accepted at edge E0 -> busy=1 from E0; shifts at edges E1..EWIDTH; done=1 and result valid in the cycle after EWIDTH; busy falls with done at edge EWIDTH+1.
- Latency: done asserts WIDTH+1 cycles after the cycle in which start was sampled high. Throughput: one operation per WIDTH+2 cycles (next start earliest in the cycle done is low and state is IDLE).
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SERIAL_SUB_FLAGS_EN defined: ports zero and ovf exist; updated at the same edge as diff. zero = (result == 0). ovf = signed overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]), using captured a/b (bin included in result). Reset to 0.
- Not defined: ports zero and ovf absent; no flag logic; all other behaviour identical.

## Test plan
- WIDTH=8, reset then a=0x05, b=0x03, bin=0, start pulse -> done exactly 9 cycles after start sampled, diff=0x02, borrow=0; zero=0, ovf=0 (flags build).
- a=0x03, b=0x05, bin=0 -> diff=0xFE, borrow=1; a=0x00, b=0x00, bin=1 -> diff=0xFF, borrow=1; a=0xFF, b=0xFF, bin=0 -> diff=0x00, borrow=0, zero=1.
- Flags build: a=0x80, b=0x01, bin=0 -> diff=0x7F, borrow=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
- Start re-asserted with new operands at cycles 3 and 5 of an active op -> ignored; result matches first operands, single done pulse, diff unchanged before done.
- rst=1 at 4th SHIFT cycle -> next cycle busy=0, diff=0, borrow=0, no done; fresh start afterwards completes correctly.
- Exhaustive sweep WIDTH=4: all a, b, bin combinations -> {borrow, diff} == (a - b - bin) mod 32 as 5-bit value, one done per op.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor (one full-subtractor cell, registered borrow); done WIDTH+1 cycles after start.
// No backpressure: start is ignored while busy. Optional zero/ovf flags under SERIAL_SUB_FLAGS_EN.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             a0, b0, d, br_nxt, last;
  logic [WIDTH-1:0] res_fin;

`ifdef SERIAL_SUB_FLAGS_EN
  logic             a_msb, b_msb;
`endif

  always_comb begin
    a0      = a_sh[0];
    b0      = b_sh[0];
    d       = a0 ^ b0 ^ br;
    br_nxt  = (~a0 & b0) | (~(a0 ^ b0) & br);
    last    = (cnt == CW'(WIDTH - 1));
    // Only WIDTH-1 bits are ever retained; the final bit joins at the last shift.
    res_fin = {d, res_sh};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      // busy/done track the state register exactly, but are flopped outputs.
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            br   <= bin;
            cnt  <= '0;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_fin[WIDTH-1:1];
          br     <= br_nxt;
          cnt    <= cnt + CW'(1);
          if (last) begin
            diff   <= res_fin;
            borrow <= br_nxt;
`ifdef SERIAL_SUB_FLAGS_EN
            zero <= (res_fin == '0);
            ovf  <= (a_msb != b_msb) && (d != a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
